// File: rtl/op_exec_unit_pkg.sv
// op_exec_unit_pkg: shared types, opcodes and FSM states for the execution stage
package op_exec_unit_pkg;
  localparam int DATA_W = 32;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [2*DATA_W-1:0] w_data_t;
  typedef logic [2:0] code_t;
  typedef logic [7:0] uinstr_t;
  localparam code_t OPC_ADD = 3'd0;
  localparam code_t OPC_SUB = 3'd1;
  localparam code_t OPC_MUL = 3'd2;
  localparam code_t OPC_MAC = 3'd3;
  typedef enum logic [1:0] {IDLE, MULT, DONE} exec_state_e;
  typedef struct packed {
    data_t   a;
    data_t   b;
    w_data_t c;
    code_t   op;
    uinstr_t uinstr;
  } bundle_t;
  function automatic logic is_mul(input code_t op);
    return op == OPC_MUL || op == OPC_MAC;
  endfunction
endpackage

// File: rtl/op_exec_unit_if.sv
// op_exec_unit_if: operand bundle in, result handshake out
interface op_exec_unit_if;
  import op_exec_unit_pkg::*;
  logic    op_valid_i;
  data_t   operand_a_i;
  data_t   operand_b_i;
  w_data_t operand_c_i;
  code_t   op_code_i;
  uinstr_t uinstr_i;
  logic    op_ready_o;
  w_data_t result_o;
  uinstr_t uinstr_o;
  logic    err_o;
  logic    result_valid_o;
  logic    result_ready_i;
  logic    overflow_o;
  modport slave (
    input  op_valid_i, operand_a_i, operand_b_i, operand_c_i, op_code_i, uinstr_i, result_ready_i,
    output op_ready_o, result_o, uinstr_o, err_o, result_valid_o, overflow_o
  );
  modport master (
    output op_valid_i, operand_a_i, operand_b_i, operand_c_i, op_code_i, uinstr_i, result_ready_i,
    input  op_ready_o, result_o, uinstr_o, err_o, result_valid_o, overflow_o
  );
endinterface

// File: rtl/op_exec_mul.sv
// op_exec_mul: iterative LSB-first shift-add multiplier, product = init_acc + a*b
// OP_EXEC_EARLY_TERM_EN: stop once the remaining multiplier bits are all zero
module op_exec_mul #(parameter int DW = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [2*DW-1:0] init_acc,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] product
);
  localparam int CW = $clog2(DW);
`ifdef OP_EXEC_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic [2*DW-1:0] acc, mcand;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   cnt;
  logic            last;
  // product is the accumulator after the current bit, so it is final on the done cycle
  assign product = acc + (mplier[0] ? mcand : '0);
  assign last = cnt == CW'(DW-1) || (EARLY && mplier[DW-1:1] == '0);
  assign done = busy && last;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (start) begin
      acc    <= init_acc;
      mcand  <= {{DW{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      busy   <= !last;
    end
  end
endmodule

// File: rtl/op_exec_unit.sv
// op_exec_unit: ADD/SUB/MUL/MAC execution stage with one-entry pending buffer
// OP_EXEC_EARLY_TERM_EN (in op_exec_mul) shortens MUL/MAC when b has few significant bits
module op_exec_unit import op_exec_unit_pkg::*; #(parameter int DW = DATA_W) (
  input logic           clk,
  input logic           rst_i,
  op_exec_unit_if.slave bus
);
  exec_state_e state;
  bundle_t     pend, in_b, lb;
  logic        pend_valid, launch_pend, launch_in, launch, store;
  logic        mul_busy, mul_done;
  w_data_t     alu, product, result;
  uinstr_t     uinstr;
  logic        err, valid, overflow;
  assign in_b = {bus.operand_a_i, bus.operand_b_i, bus.operand_c_i, bus.op_code_i, bus.uinstr_i};
  // pending bundle has priority over a fresh input
  assign launch_pend = state == IDLE && pend_valid;
  assign launch_in   = state == IDLE && !pend_valid && bus.op_valid_i;
  assign launch      = launch_pend || launch_in;
  assign store       = bus.op_valid_i && !launch_in;
  assign lb          = launch_pend ? pend : in_b;
  assign alu = lb.op == OPC_ADD ? w_data_t'(lb.a) + w_data_t'(lb.b) :
               lb.op == OPC_SUB ? w_data_t'(lb.a) - w_data_t'(lb.b) : '0;
  op_exec_mul #(.DW(DW)) u_mul (
    .clk      (clk),
    .rst      (rst_i),
    .start    (launch && is_mul(lb.op)),
    .a        (lb.a),
    .b        (lb.b),
    .init_acc (lb.op == OPC_MAC ? lb.c : '0),
    .busy     (mul_busy),
    .done     (mul_done),
    .product  (product)
  );
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
      result     <= '0;
      uinstr     <= '0;
      err        <= 1'b0;
    end else begin
      if (store) begin
        if (!pend_valid || launch_pend) begin
          pend       <= in_b;
          pend_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (launch_pend) begin
        pend_valid <= 1'b0;
      end
      case (state)
        IDLE: if (launch) begin
          uinstr <= lb.uinstr;
          err    <= lb.op > OPC_MAC;
          result <= alu;
          valid  <= !is_mul(lb.op);
          state  <= is_mul(lb.op) ? MULT : DONE;
        end
        MULT: if (mul_busy && mul_done) begin
          result <= product;
          valid  <= 1'b1;
          state  <= DONE;
        end
        DONE: if (bus.result_ready_i) begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.op_ready_o     = !pend_valid;
  assign bus.result_o       = result;
  assign bus.uinstr_o       = uinstr;
  assign bus.err_o          = err;
  assign bus.result_valid_o = valid;
  assign bus.overflow_o     = overflow;
endmodule

// File: tb/tb_op_exec_unit.sv
// tb_op_exec_unit: scoreboard bench for op_exec_unit (latency, backpressure, overflow, reset)
module tb_op_exec_unit;
  import op_exec_unit_pkg::*;
`ifdef OP_EXEC_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef struct {
    w_data_t res;
    logic    err;
    uinstr_t u;
  } exp_t;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  always #5 clk = ~clk;
  op_exec_unit_if bus();
  op_exec_unit dut (.clk(clk), .rst_i(rst_i), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input code_t op, input data_t a, input data_t b, input w_data_t c, input uinstr_t u);
    exp_t e;
    e.u   = u;
    e.err = op > 3'd3;
    e.res = op == 3'd0 ? 64'(a) + 64'(b) :
            op == 3'd1 ? 64'(a) - 64'(b) :
            op == 3'd2 ? 64'(a) * 64'(b) :
            op == 3'd3 ? 64'(a) * 64'(b) + c : 64'd0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && bus.result_valid_o && bus.result_ready_i) begin
      chk("sb_avail", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("res", bus.result_o, e.res);
        chk("err", 64'(bus.err_o), 64'(e.err));
        chk("uinstr", 64'(bus.uinstr_o), 64'(e.u));
      end
    end
  end

  task automatic drive(input code_t op, input data_t a, input data_t b, input w_data_t c, input uinstr_t u, input bit push);
    bus.op_valid_i  = 1'b1;
    bus.op_code_i   = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    bus.operand_c_i = c;
    bus.uinstr_i    = u;
    if (push) q.push_back(model(op, a, b, c, u));
    @(posedge clk); #1;
    bus.op_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (bus.result_valid_o || !bus.op_ready_o); i++) begin
      @(posedge clk); #1;
    end
    chk("idle_reached", 64'(bus.result_valid_o), 64'd0);
  endtask

  task automatic lat(input string tag, input code_t op, input data_t a, input data_t b, input w_data_t c, input uinstr_t u, input int exp_lat);
    int n;
    wait_idle();
    drive(op, a, b, c, u, 1'b1);
    n = 1;
    while (!bus.result_valid_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(n), 64'(exp_lat));
  endtask

  initial begin
    bus.op_valid_i     = 1'b0;
    bus.operand_a_i    = '0;
    bus.operand_b_i    = '0;
    bus.operand_c_i    = '0;
    bus.op_code_i      = '0;
    bus.uinstr_i       = '0;
    bus.result_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.result_valid_o), 64'd0);
    chk("rst_ready", 64'(bus.op_ready_o), 64'd1);
    chk("rst_ovf", 64'(bus.overflow_o), 64'd0);
    chk("rst_res", bus.result_o, 64'd0);
    rst_i = 1'b0;
    lat("add_lat", 3'd0, 32'd5, 32'd7, 64'd0, 8'h01, 1);
    lat("sub_lat", 3'd1, 32'd3, 32'd5, 64'd0, 8'h02, 1);
    lat("mul_max_lat", 3'd2, '1, '1, 64'd0, 8'h03, 33);
    lat("mul_b1_lat", 3'd2, 32'd9, 32'd1, 64'd0, 8'h04, EARLY ? 2 : 33);
    lat("mul_b0_lat", 3'd2, 32'd9, 32'd0, 64'd0, 8'h05, EARLY ? 2 : 33);
    lat("mac_lat", 3'd3, 32'd3, 32'd4, 64'd10, 8'h06, EARLY ? 4 : 33);
    lat("mac_wrap_lat", 3'd3, '1, '1, '1, 8'h07, 33);
    lat("bad_op_lat", 3'd7, 32'd1, 32'd2, 64'd0, 8'h08, 1);
    wait_idle();
    bus.result_ready_i = 1'b0;
    drive(3'd0, 32'd100, 32'd1, 64'd0, 8'h21, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    chk("hold_res", bus.result_o, 64'd101);
    chk("hold_valid", 64'(bus.result_valid_o), 64'd1);
    bus.result_ready_i = 1'b1;
    drive(3'd0, 32'd200, 32'd2, 64'd0, 8'h22, 1'b1);
    chk("chain_pend", 64'(bus.op_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("chain_valid", 64'(bus.result_valid_o), 64'd1);
    chk("chain_ovf", 64'(bus.overflow_o), 64'd0);
    wait_idle();
    bus.result_ready_i = 1'b0;
    drive(3'd0, 32'd10, 32'd20, 64'd0, 8'h31, 1'b1);
    drive(3'd0, 32'd1, 32'd2, 64'd0, 8'h32, 1'b1);
    drive(3'd0, 32'd5, 32'd5, 64'd0, 8'h33, 1'b0);
    chk("bp_ovf_set", 64'(bus.overflow_o), 64'd1);
    repeat (4) begin @(posedge clk); #1; end
    chk("bp_res", bus.result_o, 64'd30);
    chk("bp_uinstr", 64'(bus.uinstr_o), 64'h31);
    chk("bp_valid", 64'(bus.result_valid_o), 64'd1);
    chk("bp_pend", 64'(bus.op_ready_o), 64'd0);
    bus.result_ready_i = 1'b1;
    wait_idle();
    chk("bp_ovf_sticky", 64'(bus.overflow_o), 64'd1);
    chk("bp_drained", 64'(q.size()), 64'd0);
    drive(3'd2, '1, '1, 64'd0, 8'h41, 1'b0);
    drive(3'd0, 32'd1, 32'd1, 64'd0, 8'h42, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(bus.result_valid_o), 64'd0);
    chk("mid_rst_res", bus.result_o, 64'd0);
    chk("mid_rst_uinstr", 64'(bus.uinstr_o), 64'd0);
    chk("mid_rst_err", 64'(bus.err_o), 64'd0);
    chk("mid_rst_ready", 64'(bus.op_ready_o), 64'd1);
    chk("mid_rst_ovf", 64'(bus.overflow_o), 64'd0);
    rst_i = 1'b0;
    lat("post_rst_add", 3'd0, 32'd40, 32'd2, 64'd0, 8'h43, 1);
    wait_idle();
    chk("sb_end", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
